// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file writeback block.
// The sweep option is selected by REGFILE_WB_INIT_SWEEP_EN in the top level.
package regfile_wb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_writeback_wb_queue.sv
// Pending-write FIFO for the writeback block. Entries are exported in age order
// (index 0 = head/oldest) so the top level can do newest-wins forwarding.
module wb_queue
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH*ADDR_W-1:0]    ent_addr,
  output logic [DEPTH*DATA_W-1:0]    ent_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr_reg] <= push_addr;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign count     = count_reg;
  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] idx;
      assign idx                          = rd_ptr_reg + PTR_W'(gi);
      assign ent_valid[gi]                = (CNT_W'(gi) < count_reg);
      assign ent_addr[gi*ADDR_W +: ADDR_W] = addr_mem[idx];
      assign ent_data[gi*DATA_W +: DATA_W] = data_mem[idx];
    end
  endgenerate

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback sequencer: queues retired results, issues one write per
// cycle and forwards pending values. Optional post-reset sweep: REGFILE_WB_INIT_SWEEP_EN.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic [ADDR_W-1:0] rd_addrA,
  input  logic [ADDR_W-1:0] rd_addrB,
  output logic              fwd_hitA,
  output logic [DATA_W-1:0] fwd_dataA,
  output logic              fwd_hitB,
  output logic [DATA_W-1:0] fwd_dataB,
  output logic              busy,
  output logic              init_done
);

  localparam int CNT_W = $clog2(DEPTH+1);

  wb_state_t state_reg, state_next;
  logic      sweep_we;
  logic      sweep_done;
  logic [ADDR_W-1:0] sweep_addr;

`ifdef REGFILE_WB_INIT_SWEEP_EN
  localparam wb_state_t RESET_STATE = INIT;

  // Extra MSB flags completion once the counter passes the last register.
  logic [ADDR_W:0] sweep_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_cnt_reg <= (ADDR_W+1)'(1);
    end else if (state_reg == INIT && !sweep_done) begin
      sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
    end
  end

  assign sweep_done = sweep_cnt_reg[ADDR_W];
  assign sweep_addr = sweep_cnt_reg[ADDR_W-1:0];
`else
  localparam wb_state_t RESET_STATE = RUN;

  assign sweep_done = 1'b1;
  assign sweep_addr = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RESET_STATE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    sweep_we   = 1'b0;
    case (state_reg)
      INIT: begin
        if (sweep_done) state_next = RUN;
        else            sweep_we   = 1'b1;
      end
      RUN:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  logic              q_push, q_pop, q_full, q_empty;
  logic [ADDR_W-1:0] q_head_addr;
  logic [DATA_W-1:0] q_head_data;
  logic [CNT_W-1:0]  q_count;
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH*ADDR_W-1:0] ent_addr;
  logic [DEPTH*DATA_W-1:0] ent_data;

  assign in_ready = (state_reg == RUN) && !q_full;
  // Writes to the zero register are accepted but dropped here.
  assign q_push   = in_valid && in_ready && (in_addr != ADDR_W'(REG_ZERO));
  assign q_pop    = (state_reg == RUN) && !q_empty;

  wb_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_addr (in_addr),
    .push_data (in_data),
    .pop       (q_pop),
    .head_addr (q_head_addr),
    .head_data (q_head_data),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_addr_reg;
  logic [DATA_W-1:0] rf_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_reg   <= 1'b0;
      rf_addr_reg <= '0;
      rf_data_reg <= '0;
    end else if (sweep_we) begin
      rf_we_reg   <= 1'b1;
      rf_addr_reg <= sweep_addr;
      rf_data_reg <= '0;
    end else if (q_pop) begin
      rf_we_reg   <= 1'b1;
      rf_addr_reg <= q_head_addr;
      rf_data_reg <= q_head_data;
    end else begin
      rf_we_reg   <= 1'b0;
    end
  end

  assign rf_we   = rf_we_reg;
  assign rf_addr = rf_addr_reg;
  assign rf_data = rf_data_reg;

  logic [2*ADDR_W-1:0] rd_addr_vec;
  logic [1:0]          fwd_hit_vec;
  logic [2*DATA_W-1:0] fwd_data_vec;

  assign rd_addr_vec = {rd_addrB, rd_addrA};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic              hit;
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] ra;

      assign ra = rd_addr_vec[gi*ADDR_W +: ADDR_W];

      // Oldest source first so each later (newer) match overrides it.
      always_comb begin
        hit  = 1'b0;
        data = '0;
        if (rf_we_reg && rf_addr_reg == ra) begin
          hit  = 1'b1;
          data = rf_data_reg;
        end
        for (int k = 0; k < DEPTH; k++) begin
          if (ent_valid[k] && ent_addr[k*ADDR_W +: ADDR_W] == ra) begin
            hit  = 1'b1;
            data = ent_data[k*DATA_W +: DATA_W];
          end
        end
        if (ra == ADDR_W'(REG_ZERO)) begin
          hit  = 1'b0;
          data = '0;
        end
      end

      assign fwd_hit_vec[gi]                 = hit;
      assign fwd_data_vec[gi*DATA_W +: DATA_W] = data;
    end
  endgenerate

  assign fwd_hitA  = fwd_hit_vec[0];
  assign fwd_hitB  = fwd_hit_vec[1];
  assign fwd_dataA = fwd_data_vec[0 +: DATA_W];
  assign fwd_dataB = fwd_data_vec[DATA_W +: DATA_W];

  assign busy      = (q_count != '0) || rf_we_reg || (state_reg == INIT);
  assign init_done = (state_reg == RUN);

endmodule
